// File: rtl/ext_rx_packetizer.sv
// ============================================================================
// ext_rx_packetizer : groups UART RX bytes into 1- or 2-byte packets, queued
//                     in a small FIFO drained through a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_rx_packetizer #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TIMEOUT_US  = 1000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_rx_dv,
  input  logic [7:0]                    i_rx_byte,
  output logic                          o_pkt_valid,
  output logic [7:0]                    o_pkt_byte1,
  output logic [7:0]                    o_pkt_byte2,
  output logic                          o_pkt_single,
  input  logic                          i_pkt_ready,
  output logic                          o_overflow,
  output logic [7:0]                    o_drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int CW             = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_B2 = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic [7:0]      byte1_q;

  logic            push;
  logic [7:0]      push_b2;
  logic            push_single;

  logic [AW:0]     rd_ptr;
  logic [AW:0]     wr_ptr;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            drop;
  logic [16:0]     mem [FIFO_DEPTH];
  logic [16:0]     head;

  // A second byte wins over the timeout when both land in the same cycle.
  always_comb begin
    push        = 1'b0;
    push_b2     = 8'h00;
    push_single = 1'b0;
    if (state == WAIT_B2) begin
      if (i_rx_dv) begin
        push    = 1'b1;
        push_b2 = i_rx_byte;
      end else if (tmo_cnt == CNT_LAST) begin
        push        = 1'b1;
        push_single = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      byte1_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_dv) begin
            byte1_q <= i_rx_byte;
            tmo_cnt <= '0;
            state   <= WAIT_B2;
          end
        end
        WAIT_B2: begin
          if (push) state <= IDLE;
          else      tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_fifo_count = wr_ptr - rd_ptr;
  assign o_pkt_valid  = (o_fifo_count != '0);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop          = o_pkt_valid && i_pkt_ready;
  assign wr_en        = push && (!full || pop);
  assign drop         = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {byte1_q, push_b2, push_single};
  end

  // Storage is not reset, so head fields are masked while the FIFO is empty.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign o_pkt_byte1  = o_pkt_valid ? head[16:9] : 8'h00;
  assign o_pkt_byte2  = o_pkt_valid ? head[8:1]  : 8'h00;
  assign o_pkt_single = o_pkt_valid ? head[0]    : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      o_overflow   <= 1'b0;
      o_drop_count <= 8'h00;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      o_overflow <= drop;
      if (drop && (o_drop_count != 8'hFF)) o_drop_count <= o_drop_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/ext_rx_packetizer.md
# ext_rx_packetizer

Groups the byte stream from the external-sensor UART receiver into measurement packets and queues them for the transmit/forwarding stage. A packet is either two bytes (header + measurement) or a single byte closed by an inter-byte timeout. Completed packets go into a small packet FIFO drained through a valid/ready handshake. The block sits between the external `uart_top` RX outputs and the transmit FSM.

## Interface

- `CLK_FREQ_HZ`, 25_000_000: system clock frequency.
- `TIMEOUT_US`, 1000: inter-byte timeout; `TIMEOUT_CYCLES = CLK_FREQ_HZ/1_000_000*TIMEOUT_US`, must be ≥ 2.
- `FIFO_DEPTH`, 4: packet entries, power of two, ≥ 2.

- `clk`  in  1: system clock; all logic on rising edge. One clock only.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_rx_dv`  in  1: one-cycle strobe, received byte valid.
- `i_rx_byte`  in  8: received byte, valid with `i_rx_dv`.
- `o_pkt_valid`  out  1: FIFO head holds a packet.
- `o_pkt_byte1`  out  8: head packet first byte.
- `o_pkt_byte2`  out  8: head packet second byte; 0x00 for single-byte packets.
- `o_pkt_single`  out  1: head packet closed by timeout.
- `i_pkt_ready`  in  1: consumer accepts head when `o_pkt_valid`.
- `o_overflow`  out  1: one-cycle pulse, completed packet dropped.
- `o_drop_count`  out  8: dropped packets, saturates at 255.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1: entries held.

## Operation

- Assembler FSM, states IDLE and WAIT_B2.
- IDLE: on `i_rx_dv`, capture byte1, clear timeout counter, go to WAIT_B2.
- WAIT_B2, each cycle:
  - `i_rx_dv`: write {byte1, `i_rx_byte`, single=0}, go to IDLE.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: write {byte1, 0x00, single=1}, go to IDLE.
  - Otherwise: counter +1.
- `i_rx_dv` has priority over timeout in the same cycle.
- FIFO: circular buffer, read/write pointers one bit wider than the address.
  - Head outputs are driven combinationally from storage at the read pointer.
  - `o_pkt_valid` = count ≠ 0.
- Pop: `o_pkt_valid && i_pkt_ready`. `i_pkt_ready` is ignored when empty.
- Push while full:
  - Pop in same cycle: push accepted, count unchanged.
  - No pop: packet dropped, `o_overflow` pulses the next cycle, `o_drop_count` +1 (saturating), FSM still returns to IDLE.
- Push and pop in same cycle, not full: both occur, count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full when address bits are equal and MSBs differ.
- Reset (any time, including mid-packet):
  - FSM to IDLE, counter 0, partial byte1 discarded, FIFO emptied.
  - Outputs: `o_pkt_valid`=0, `o_pkt_byte1`=0, `o_pkt_byte2`=0, `o_pkt_single`=0, `o_overflow`=0, `o_drop_count`=0, `o_fifo_count`=0.
  - Storage contents need not be reset, but head outputs read 0 while empty after reset.

## Timing

- Byte1 captured at edge E0 (strobe in cycle 0). Cycles 1..TIMEOUT_CYCLES form the byte2 window.
- Two-byte packet: strobe in cycle k (1 ≤ k ≤ TIMEOUT_CYCLES). Entry written at end of cycle k; `o_pkt_valid` high in cycle k+1 if FIFO was empty.
- Single-byte packet: written at end of cycle TIMEOUT_CYCLES; visible in cycle TIMEOUT_CYCLES+1.
- Strobe in cycle TIMEOUT_CYCLES+1 starts a new packet.
- Pop updates head and count at the accepting edge; next entry is presented the following cycle.
- `o_overflow` is high exactly one cycle per dropped packet.
- Sustained throughput: one packet per two `i_rx_dv` strobes. Minimum strobe spacing is 1 cycle.

## Test plan

Bench parameters: CLK_FREQ_HZ=1_000_000, TIMEOUT_US=16 (TIMEOUT_CYCLES=16), FIFO_DEPTH=4.

- Two-byte packet: strobes 0xA1 in cycle 0 and 0x55 in cycle 5, ready=0 -> from cycle 6: valid=1, byte1=0xA1, byte2=0x55, single=0, count=1; ready pulse -> valid=0, count=0.
- Timeout: strobe 0x3C only -> valid rises exactly in cycle 17 with byte1=0x3C, byte2=0x00, single=1; no change in cycle 16.
- Timeout boundary: strobe 0x10 in cycle 0, then 0x20 in cycle 16 -> one two-byte packet {0x10,0x20}. Repeat with 0x20 in cycle 17 -> single packet {0x10} then 0x20 opens a new packet.
- Overflow: five two-byte packets {0x01,0x02}..{0x09,0x0A}, ready=0 -> count=4, fifth dropped, one `o_overflow` pulse, drop_count=1. Draining yields the first four in order, pointers wrap correctly on refill.
- Full with simultaneous pop: FIFO full, ready=1 in the cycle the fifth packet completes -> no overflow, count stays 4, order preserved. Also 300 drops -> drop_count holds 255.
- Reset mid-operation: assert `rst_n`=0 in WAIT_B2 with 2 entries queued -> all outputs 0 immediately. After release, strobe 0x77 in cycle 0 and 0x88 in cycle 3 -> only packet {0x77,0x88}, no stale byte1.
